bitstream_buffer_fill: RTL and testbench
========================================

// Module: bitstream_buffer_fill
// PURPOSE
//  Circular 128-bit bitstream buffer: the consumer of the parser's 7-bit bit program counter (pc).
//  - Prefetches 16-bit words from external bitstream memory.
//  - Presents the 16-bit window starting at the registered pc to the parser.
//  - Refills word slots as the parser's pc moves past them.
//  Sits between the bitstream memory port and the parser/pc_decoding logic.
// PARAMETERS
//  ADDR_W     17  bitstream memory word-address width
//  READY_MIN  3   minimum valid words (current word included) for bs_ready
// PORTS
//  clk            in   1       clock; all state on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse: (re)start fetching at start_addr
//  start_addr     in   ADDR_W  first memory word address of the stream
//  pc             in   7       next bit pointer from parser (combinational, sampled every clk)
//  mem_rd_req     out  1       1-cycle read request pulse
//  mem_rd_addr    out  ADDR_W  word address, valid while mem_rd_req=1
//  mem_rd_valid   in   1       read data valid, any latency >=1 cycle after req
//  mem_rd_data    in   16      read data word, MSB = earliest bitstream bit
//  bs_window      out  16      buffer bits [pc_q .. pc_q+15] mod 128, bit15 = bit at pc_q
//  bs_ready       out  1       valid word count >= READY_MIN and state==STREAM
//  underrun       out  1       sticky: pc advanced while bs_ready==0
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - pc_q=0, state=IDLE, count=0, wr_slot=0, rd_addr=0, outstanding=0, drop=0.
//   - Outputs: mem_rd_req=0, mem_rd_addr=0, bs_ready=0, underrun=0, bs_window=0.
//   - Storage contents need not be cleared.
//  Storage: 8 slots x 16 bits. Slot k holds buffer bits 16k..16k+15. pc_q <= pc every clk.
//  bs_window: combinational from storage and pc_q (0 latency). Wraps 127->0 across slot 7->0.
//  Word accounting:
//   - freed = (pc[6:4] - pc_q[6:4]) mod 8, i.e. slots passed this cycle (0..2).
//   - count_next = count + mem_rd_valid_accepted - freed.
//   - freed > count is an underrun: clamp count to 0 and set underrun.
//  Write: accepted data goes to wr_slot; wr_slot increments mod 8.
//  Requests:
//   - Max 1 outstanding.
//   - Issue mem_rd_req when state!=IDLE, outstanding=0 and count<8; same cycle rd_addr increments.
//   - rd_addr wraps modulo 2^ADDR_W.
//   - outstanding clears on mem_rd_valid.
//  FSM:
//   - IDLE    : no requests; start -> PREFILL.
//   - PREFILL : fetch until count==8 -> STREAM; bs_ready=0 here.
//   - STREAM  : refill continuously; bs_ready per count.
//   - start in any state -> PREFILL: rd_addr=start_addr, count=0, wr_slot=pc[6:4].
//     Parser holds pc at a slot boundary (pc[3:0]==0) across start.
//  Simultaneous start and mem_rd_valid: the data belongs to the old stream and is discarded.
//   - If outstanding=1 at start (and no valid that cycle): set drop=1.
//   - Next mem_rd_valid clears drop and outstanding, writes nothing, does not change count.
//   - No new request is issued while drop=1.
//  Simultaneous write and free in one cycle: both take effect per count_next.
//   - A write never targets a slot still counted valid, since count<8 gates requests.
//  underrun:
//   - Set when pc!=pc_q while bs_ready=0 in STREAM, or on a freed>count clamp.
//   - Cleared only by reset or start.
//  mem_rd_valid with outstanding=0: ignored (no write, no count change).
// TESTING
//  1 Reset, start addr=0x100, mem latency 2, pc held 0 -> 8 reqs at 0x100..0x107; PREFILL->STREAM; bs_ready=1; bs_window=word0.
//  2 Words 0xABCD,0x1234; pc 0->4 -> bs_window=0xBCD1; pc=16 next -> freed=1, req 0x108 issued, written to slot 0.
//  3 pc 120->135 wrap (pc=7) with slot7=0xFFFF, slot0=0x0000 -> at pc_q=120 bs_window=0xFF00; slot7 freed; no underrun.
//  4 Memory stalls, parser advances 31 bits/cycle -> bs_ready drops at count<3; further pc change sets underrun=1, sticky until start.
//  5 start asserted while request outstanding, old data returns -> data discarded; next req addr=new start_addr; count 0->8 from new data only.
//  6 reset_n low mid-PREFILL with req pending -> all outputs 0 immediately; late mem_rd_valid after release ignored.

Source files
------------

// File: rtl/bitstream_buffer_fill.sv
// bitstream_buffer_fill
// Circular 128-bit bitstream buffer sitting between the bitstream memory
// port and the parser. Eight 16-bit slots are prefetched from memory and
// refilled as the parser's bit pointer moves past them. The 16-bit window
// starting at the registered pointer is presented to the parser with zero
// latency and wraps from bit 127 back to bit 0.
//
// Ports
//   clk           clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse, (re)start fetching at start_addr
//   start_addr    first memory word address of the stream
//   pc            next bit pointer from the parser, sampled every clock
//   mem_rd_req    one-cycle read request pulse
//   mem_rd_addr   word address, valid while mem_rd_req is high
//   mem_rd_valid  read data valid, any latency of one or more cycles
//   mem_rd_data   read data word, MSB is the earliest bitstream bit
//   bs_window     buffer bits [pc_q .. pc_q+15] mod 128, bit 15 = bit at pc_q
//   bs_ready      enough valid words buffered and streaming
//   underrun      sticky flag, the parser outran the buffer

module bitstream_buffer_fill #(
   parameter int ADDR_W    = 17,
   parameter int READY_MIN = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [6:0]        pc,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [15:0]       mem_rd_data,
   output logic [15:0]       bs_window,
   output logic              bs_ready,
   output logic              underrun
);

   typedef enum logic [1:0] {
      IDLE,
      PREFILL,
      STREAM
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [6:0]        pc_q;
   logic [3:0]        count;
   logic [3:0]        count_next;
   logic [2:0]        wr_slot;
   logic [ADDR_W-1:0] rd_addr;
   logic              outstanding;
   logic              drop;
   logic              underrun_q;

   logic [15:0]       slots [8];

   logic [2:0]        freed;
   logic              accept;
   logic              issue;
   logic              clamp;
   logic              moved_unready;
   logic [6:0]        win_idx;

   // Slot bookkeeping for this cycle. freed counts how many slot
   // boundaries the parser crossed between the registered pointer and the
   // new one. Data is only accepted for a request of the current stream,
   // so a drop in progress or a restart this cycle discards it. A new
   // request needs a free slot and no read in flight; a restart suppresses
   // it because the address register is about to be reloaded.
   always_comb begin
      freed         = pc[6:4] - pc_q[6:4];
      accept        = mem_rd_valid && outstanding && !drop && !start;
      issue         = (state != IDLE) && !outstanding && !drop
                      && (count < 4'd8) && !start;
      clamp         = (state != IDLE) && ({1'b0, freed} > count);
      moved_unready = (state == STREAM) && (pc != pc_q) && !bs_ready;
   end

   // Valid word count. A write and a free in the same cycle both apply;
   // freeing more slots than are valid is an underrun and pins the count
   // at zero instead of letting it wrap.
   always_comb begin
      count_next = count;
      if (state != IDLE) begin
         if (clamp) begin
            count_next = 4'd0;
         end else begin
            count_next = count + {3'b000, accept} - {1'b0, freed};
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A restart wins from any state; prefill ends once
   // every slot holds a word of the new stream.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = PREFILL;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            PREFILL: if (count == 4'd8) state_next = STREAM;
            STREAM:  state_next = STREAM;
            default: state_next = IDLE;
         endcase
      end
   end

   // Pointer, fill and request tracking. On a restart with a read still
   // in flight the returning word belongs to the old stream; drop remembers
   // to swallow it and blocks new requests until it has come back. If the
   // old word returns in the restart cycle itself it is simply discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= 7'd0;
         count       <= 4'd0;
         wr_slot     <= 3'd0;
         rd_addr     <= '0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         pc_q <= pc;
         if (start) begin
            count      <= 4'd0;
            wr_slot    <= pc[6:4];
            rd_addr    <= start_addr;
            underrun_q <= 1'b0;
            if (outstanding) begin
               if (mem_rd_valid) begin
                  outstanding <= 1'b0;
                  drop        <= 1'b0;
               end else begin
                  drop <= 1'b1;
               end
            end
         end else begin
            count <= count_next;
            if (accept) begin
               wr_slot <= wr_slot + 3'd1;
            end
            if (issue) begin
               outstanding <= 1'b1;
               rd_addr     <= rd_addr + ADDR_W'(1);
            end else if (mem_rd_valid && outstanding) begin
               outstanding <= 1'b0;
               drop        <= 1'b0;
            end
            if (clamp || moved_unready) begin
               underrun_q <= 1'b1;
            end
         end
      end
   end

   // Word storage. Contents are never cleared; the window is masked until
   // a stream has been started.
   always_ff @(posedge clk) begin
      if (accept) begin
         slots[wr_slot] <= mem_rd_data;
      end
   end

   // Window extraction. Buffer bit b lives in slot b/16 at word bit
   // 15 - b%16, so the seven-bit index wraps naturally from 127 to 0.
   always_comb begin
      bs_window = 16'h0000;
      win_idx   = 7'd0;
      if (state != IDLE) begin
         for (int i = 0; i < 16; i++) begin
            win_idx          = pc_q + 7'(i);
            bs_window[15-i]  = slots[win_idx[6:4]][4'd15 - win_idx[3:0]];
         end
      end
   end

   assign mem_rd_req  = issue;
   assign mem_rd_addr = rd_addr;
   assign bs_ready    = (state == STREAM) && (count >= 4'(READY_MIN));
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_bitstream_buffer_fill.sv
// tb_bitstream_buffer_fill
// Self-checking bench for bitstream_buffer_fill. A bus model answers read
// requests with configurable latency and stalls. A stream-level reference
// tracks the absolute bit position of the parser and the number of words
// delivered for the current stream, and from those derives the expected
// request pattern, bs_ready, underrun and window contents.

module tb_bitstream_buffer_fill;

   localparam int P_IDLE   = 0;
   localparam int P_PRE    = 1;
   localparam int P_STREAM = 2;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [16:0] start_addr;
   logic [6:0]  pc;
   logic        mem_rd_req;
   logic [16:0] mem_rd_addr;
   logic        mem_rd_valid;
   logic [15:0] mem_rd_data;
   logic [15:0] bs_window;
   logic        bs_ready;
   logic        underrun;

   bitstream_buffer_fill #(.ADDR_W(17), .READY_MIN(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .start_addr   (start_addr),
      .pc           (pc),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data),
      .bs_window    (bs_window),
      .bs_ready     (bs_ready),
      .underrun     (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // bus model
   logic        pend = 1'b0;
   logic [16:0] pend_addr = '0;
   int          pend_gen = 0;
   int          pend_due = 0;
   int          lat = 2;
   logic        stall = 1'b0;
   int          cyc = 0;
   logic        last_req = 1'b0;

   // stream-level reference
   int          phase = P_IDLE;
   int          cnt_m = 0;
   int          gen = 0;
   int          abs_pc = 0;
   int          start_abs = 0;
   logic [16:0] s_addr_m = '0;
   logic [16:0] exp_addr = '0;
   int          req_count = 0;
   logic        under_m = 1'b0;
   logic        ready_prev = 1'b0;
   logic [6:0]  pc_prev = '0;
   logic [6:0]  pcv = '0;

   typedef struct {
      logic [6:0]  pc;
      logic [15:0] window;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [16:0] a);
      logic [31:0] h;
      case (a)
         17'h100: word_of = 16'hABCD;
         17'h101: word_of = 16'h1234;
         17'h102: word_of = 16'h5678;
         17'h103: word_of = 16'h9ABC;
         17'h104: word_of = 16'hDEF0;
         17'h105: word_of = 16'h0F1E;
         17'h106: word_of = 16'h2D3C;
         17'h107: word_of = 16'hFFFF;
         17'h108: word_of = 16'h0000;
         17'h109: word_of = 16'hC3A5;
         default: begin
            h       = {15'b0, a} * 32'h9E3779B1;
            word_of = h[31:16] ^ h[15:0];
         end
      endcase
   endfunction

   // Sixteen stream bits starting at the parser's absolute position.
   function automatic logic [15:0] model_window();
      logic [15:0] w;
      logic [15:0] word;
      int          r;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         r         = abs_pc - start_abs + i;
         word      = word_of(s_addr_m + 17'(r / 16));
         w[15-i]   = word[15 - (r % 16)];
      end
      return w;
   endfunction

   task automatic model_reset();
      phase      = P_IDLE;
      cnt_m      = 0;
      gen++;
      under_m    = 1'b0;
      ready_prev = 1'b0;
      pc_prev    = 7'd0;
      exp_addr   = '0;
   endtask

   // One clock cycle: drive inputs, check the request, clock, advance the
   // reference and check the registered outputs.
   task automatic applyStimulus(input logic start_i, input logic [6:0] pc_i, input logic [16:0] addr_i);
      logic       v;
      int         vtag;
      logic       exp_req;
      logic       got_req;
      logic [6:0] diff;
      int         new_abs;
      int         freed;
      int         cnt_old;
      start      = start_i;
      start_addr = addr_i;
      pc         = pc_i;
      v          = 1'b0;
      vtag       = -1;
      if (pend && cyc >= pend_due && !stall) begin
         mem_rd_valid = 1'b1;
         mem_rd_data  = word_of(pend_addr);
         v            = 1'b1;
         vtag         = pend_gen;
      end else begin
         mem_rd_valid = 1'b0;
         mem_rd_data  = 16'($urandom);
      end
      #2;
      exp_req = !start_i && (phase != P_IDLE) && !pend && (cnt_m < 8);
      chk("mem_rd_req", {31'b0, mem_rd_req}, {31'b0, exp_req});
      got_req = mem_rd_req;
      if (got_req) begin
         chk("mem_rd_addr", {15'b0, mem_rd_addr}, {15'b0, exp_addr});
         exp_addr = exp_addr + 17'd1;
         req_count++;
      end
      if (v) pend = 1'b0;
      if (got_req) begin
         pend      = 1'b1;
         pend_addr = mem_rd_addr;
         pend_gen  = gen;
         pend_due  = cyc + lat;
      end
      @(posedge clk);
      #1;
      if (start_i) begin
         gen++;
         phase     = P_PRE;
         cnt_m     = 0;
         start_abs = int'(pc_i);
         abs_pc    = start_abs;
         s_addr_m  = addr_i;
         under_m   = 1'b0;
         exp_addr  = addr_i;
         req_count = 0;
      end else if (phase != P_IDLE) begin
         diff    = pc_i - pc_prev;
         new_abs = abs_pc + int'(diff);
         freed   = (new_abs / 16) - (abs_pc / 16);
         if (phase == P_STREAM && pc_i != pc_prev && !ready_prev) under_m = 1'b1;
         cnt_old = cnt_m;
         if (freed > cnt_old) begin
            cnt_m   = 0;
            under_m = 1'b1;
         end else begin
            cnt_m = cnt_old + ((v && vtag == gen) ? 1 : 0) - freed;
         end
         if (phase == P_PRE && cnt_old == 8) phase = P_STREAM;
         abs_pc = new_abs;
      end
      pc_prev    = pc_i;
      ready_prev = (phase == P_STREAM) && (cnt_m >= 3);
      cyc++;
      last_req = got_req;
      checkOutput();
   endtask

   task automatic checkOutput();
      chk("bs_ready", {31'b0, bs_ready}, {31'b0, ready_prev});
      chk("underrun", {31'b0, underrun}, {31'b0, under_m});
      if (ready_prev) chk("bs_window", {16'b0, bs_window}, {16'b0, model_window()});
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{7'd0,   16'hABCD};
      vecs[1]  = '{7'd4,   16'hBCD1};
      vecs[2]  = '{7'd16,  16'h1234};
      vecs[3]  = '{7'd20,  16'h2345};
      vecs[4]  = '{7'd40,  16'h789A};
      vecs[5]  = '{7'd64,  16'hDEF0};
      vecs[6]  = '{7'd88,  16'h1E2D};
      vecs[7]  = '{7'd112, 16'hFFFF};
      vecs[8]  = '{7'd120, 16'hFF00};
      vecs[9]  = '{7'd7,   16'h0061};
      vecs[10] = '{7'd7,   16'h0061};

      reset_n      = 1'b1;
      start        = 1'b0;
      start_addr   = '0;
      pc           = '0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      #1 reset_n   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_req",    {31'b0, mem_rd_req}, 32'd0);
      chk("reset_addr",   {15'b0, mem_rd_addr}, 32'd0);
      chk("reset_ready",  {31'b0, bs_ready}, 32'd0);
      chk("reset_under",  {31'b0, underrun}, 32'd0);
      chk("reset_window", {16'b0, bs_window}, 32'd0);
      reset_n = 1'b1;

      // prefill from 0x100 with latency 2, parser parked at bit 0
      $display("[TB] prefill");
      lat = 2;
      pcv = 7'd0;
      applyStimulus(1'b1, pcv, 17'h100);
      for (int i = 0; i < 100 && !bs_ready; i++) applyStimulus(1'b0, pcv, 17'h0);
      chk("prefill_ready", {31'b0, bs_ready}, 32'd1);
      chk("prefill_reqs", req_count, 32'd8);
      chk("prefill_window", {16'b0, bs_window}, 32'hABCD);

      // table of parser positions, including the 127 -> 0 wrap
      $display("[TB] window table");
      lat = 1;
      for (int i = 0; i < 11; i++) begin
         pcv = vecs[i].pc;
         applyStimulus(1'b0, pcv, 17'h0);
         chk($sformatf("vec%0d_window", i), {16'b0, bs_window}, {16'b0, vecs[i].window});
         chk($sformatf("vec%0d_ready", i), {31'b0, bs_ready}, 32'd1);
      end

      // memory stalls while the parser races ahead
      $display("[TB] stall and underrun");
      stall = 1'b1;
      for (int i = 0; i < 10 && ready_prev; i++) begin
         pcv = pcv + 7'd31;
         applyStimulus(1'b0, pcv, 17'h0);
      end
      chk("stall_ready_drop", {31'b0, bs_ready}, 32'd0);
      chk("stall_no_underrun_yet", {31'b0, underrun}, 32'd0);
      pcv = pcv + 7'd1;
      applyStimulus(1'b0, pcv, 17'h0);
      chk("underrun_set", {31'b0, underrun}, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, pcv, 17'h0);
      chk("underrun_sticky", {31'b0, underrun}, 32'd1);

      // restart with a read in flight; the old word must be discarded
      $display("[TB] restart with read in flight");
      stall = 1'b0;
      lat   = 3;
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b0, pcv, 17'h0);
         if (last_req) break;
      end
      chk("restart_req_seen", {31'b0, last_req}, 32'd1);
      pcv = 7'd48;
      applyStimulus(1'b1, pcv, 17'h1FFFC);
      chk("restart_under_clear", {31'b0, underrun}, 32'd0);
      for (int i = 0; i < 100 && !bs_ready; i++) applyStimulus(1'b0, pcv, 17'h0);
      chk("restart_ready", {31'b0, bs_ready}, 32'd1);
      chk("restart_reqs", req_count, 32'd8);
      chk("restart_window", {16'b0, bs_window}, {16'b0, word_of(17'h1FFFC)});

      // asynchronous reset in the middle of prefill with a read pending
      $display("[TB] reset mid prefill");
      lat = 2;
      pcv = 7'd0;
      applyStimulus(1'b1, pcv, 17'h040);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, pcv, 17'h0);
         if (last_req) break;
      end
      mem_rd_valid = 1'b0;
      start        = 1'b0;
      #2 reset_n   = 1'b0;
      #1;
      chk("midreset_req",    {31'b0, mem_rd_req}, 32'd0);
      chk("midreset_addr",   {15'b0, mem_rd_addr}, 32'd0);
      chk("midreset_ready",  {31'b0, bs_ready}, 32'd0);
      chk("midreset_under",  {31'b0, underrun}, 32'd0);
      chk("midreset_window", {16'b0, bs_window}, 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 10 && pend; i++) applyStimulus(1'b0, pcv, 17'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, pcv, 17'h0);
      chk("late_valid_req", {31'b0, mem_rd_req}, 32'd0);
      chk("late_valid_window", {16'b0, bs_window}, 32'd0);

      // randomized traffic against the stream reference
      $display("[TB] random traffic");
      for (int k = 0; k < 3000; k++) begin
         lat   = int'($urandom_range(1, 4));
         stall = ($urandom_range(0, 7) == 0);
         if (k % 700 == 0) begin
            pcv = 7'(16 * $urandom_range(0, 7));
            applyStimulus(1'b1, pcv, 17'($urandom));
         end else begin
            if (ready_prev) pcv = pcv + 7'($urandom_range(0, 31));
            applyStimulus(1'b0, pcv, 17'h0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
